// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter sharing one ripple add/sub datapath (IDLE -> EXEC -> RESP).
// Optional build macro ADDSUB_ARBITER_OVF_EN adds the registered signed-overflow output rsp_ovf.
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
`ifdef ADDSUB_ARBITER_OVF_EN
    output logic             rsp_ovf,
`endif
    output logic             rsp_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_mode;
    logic [WIDTH-1:0] req_a [2];
    logic [WIDTH-1:0] req_b [2];

    logic             grant_any;
    logic             grant_id;
    logic             last_reg;

    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic             op_mode_reg;
    logic             op_id_reg;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_out_reg;
    logic             rsp_cout_reg;

    assign req_valid = {req1_valid, req1_valid ? 1'b0 : 1'b0} | {1'b0, req0_valid};
    assign req_mode  = {req1_mode, req0_mode};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_any = |req_valid;
        grant_id  = req_valid[1];
        if (&req_valid) begin
            grant_id = ~last_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (state_reg == IDLE) && grant_any
                                   && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operands are latched at acceptance so later requester changes cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            op_mode_reg <= 1'b0;
            op_id_reg   <= 1'b0;
        end else if ((state_reg == IDLE) && grant_any) begin
            op_a_reg    <= req_a[grant_id];
            op_b_reg    <= req_b[grant_id];
            op_mode_reg <= req_mode[grant_id];
            op_id_reg   <= grant_id;
        end
    end

    // Subtract is A + ~B + 1: invert B and feed the mode bit in as carry-in.
    assign b_eff    = op_b_reg ^ {WIDTH{op_mode_reg}};
    assign carry[0] = op_mode_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign sum[gi]     = op_a_reg[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi+1] = (op_a_reg[gi] & b_eff[gi])
                               | (op_a_reg[gi] & carry[gi])
                               | (b_eff[gi] & carry[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_out_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= op_id_reg;
            rsp_out_reg   <= sum;
            rsp_cout_reg  <= carry[WIDTH];
        end else if ((state_reg == RESP) && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // The fairness pointer only advances once a result has actually been consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (rsp_valid_reg && rsp_ready) begin
            last_reg <= rsp_id_reg;
        end
    end

`ifdef ADDSUB_ARBITER_OVF_EN
    logic ovf_calc;
    logic rsp_ovf_reg;

    assign ovf_calc = (op_a_reg[WIDTH-1] == b_eff[WIDTH-1])
                      && (sum[WIDTH-1] != op_a_reg[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_ovf_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_ovf_reg <= ovf_calc;
        end
    end

    assign rsp_ovf = rsp_ovf_reg;
`endif

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_out   = rsp_out_reg;
    assign rsp_cout  = rsp_cout_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and randomized bench for addsub_arbiter, checked against an arithmetic reference model.
// Also exercises rsp_ovf when built with ADDSUB_ARBITER_OVF_EN.
module tb_addsub_arbiter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_mode = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_mode = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [W-1:0] rsp_out;
    logic         rsp_cout;
`ifdef ADDSUB_ARBITER_OVF_EN
    logic         rsp_ovf;
`endif

    int errors = 0;
    int checks = 0;
    int last_g = 1;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_mode  (req1_mode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
`ifdef ADDSUB_ARBITER_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .rsp_cout   (rsp_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_out(input int a, input int b, input int m);
        int r;
        r = (m != 0) ? (a - b) : (a + b);
        return ((r % MOD) + MOD) % MOD;
    endfunction

    function automatic int ref_cout(input int a, input int b, input int m);
        if (m != 0) return (a >= b) ? 1 : 0;
        return (a + b >= MOD) ? 1 : 0;
    endfunction

    function automatic int ref_ovf(input int a, input int b, input int m);
        int sa, sb, r;
        sa = (a >= MOD / 2) ? a - MOD : a;
        sb = (b >= MOD / 2) ? b - MOD : b;
        r  = (m != 0) ? (sa - sb) : (sa + sb);
        return (r >= MOD / 2 || r < -(MOD / 2)) ? 1 : 0;
    endfunction

    function automatic int pick(input bit v0, input bit v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    task automatic txn(input bit v0, input bit v1,
                       input int a0, input int b0, input int m0,
                       input int a1, input int b1, input int m1,
                       input int stall);
        int g, ea, eb, em, g2;
        logic [W-1:0] out_hold;
        @(negedge clk);
        req0_valid = v0; req0_a = W'(a0); req0_b = W'(b0); req0_mode = m0[0];
        req1_valid = v1; req1_a = W'(a1); req1_b = W'(b1); req1_mode = m1[0];
        rsp_ready  = (stall == 0);
        #1;
        check("ready_mutex", 32'(req0_ready & req1_ready), 32'd0);
        if (!v0 && !v1) begin
            check("idle_r0", 32'(req0_ready), 32'd0);
            check("idle_r1", 32'(req1_ready), 32'd0);
            $display("txn idle cycle");
            return;
        end
        g  = pick(v0, v1, last_g);
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        em = (g == 1) ? m1 : m0;
        check("grant_r0", 32'(req0_ready), 32'(g == 0));
        check("grant_r1", 32'(req1_ready), 32'(g == 1));
        @(posedge clk); #1;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_mode = 1'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom); req1_mode = 1'($urandom);
        check("exec_r0", 32'(req0_ready), 32'd0);
        check("exec_r1", 32'(req1_ready), 32'd0);
        check("exec_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_out", 32'(rsp_out), 32'(ref_out(ea, eb, em)));
        check("rsp_cout", 32'(rsp_cout), 32'(ref_cout(ea, eb, em)));
`ifdef ADDSUB_ARBITER_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(ref_ovf(ea, eb, em)));
`endif
        out_hold = W'(ref_out(ea, eb, em));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_out", 32'(rsp_out), 32'(out_hold));
            check("hold_id", 32'(rsp_id), 32'(g));
            check("hold_r0", 32'(req0_ready), 32'd0);
            check("hold_r1", 32'(req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        last_g = g;
        check("done_valid", 32'(rsp_valid), 32'd0);
        g2 = pick(v0, v1, last_g);
        check("next_r0", 32'(req0_ready), 32'(g2 == 0));
        check("next_r1", 32'(req1_ready), 32'(g2 == 1));
        $display("txn grant=%0d a=%0d b=%0d mode=%0d out=%0d cout=%0d stall=%0d",
                 g, ea, eb, em, rsp_out, rsp_cout, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesters pending: nothing may be granted.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_out", 32'(rsp_out), 32'd0);
        check("rst_cout", 32'(rsp_cout), 32'd0);
        check("rst_r0", 32'(req0_ready), 32'd0);
        check("rst_r1", 32'(req1_ready), 32'd0);
`ifdef ADDSUB_ARBITER_OVF_EN
        check("rst_ovf", 32'(rsp_ovf), 32'd0);
`endif
        $display("reset checked");
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        txn(1, 0, 3, 4, 0, 0, 0, 0, 0);
        txn(0, 1, 0, 0, 0, 2, 5, 1, 0);
        txn(1, 0, 15, 1, 0, 0, 0, 0, 0);
        txn(1, 0, 6, 6, 0, 0, 0, 0, 5);
        txn(1, 0, 7, 1, 0, 0, 0, 0, 0);
        txn(0, 1, 0, 0, 0, 8, 1, 1, 0);
        txn(1, 0, 3, 2, 1, 0, 0, 0, 0);
        txn(0, 1, 0, 0, 0, 3, 9, 1, 0);
        txn(1, 0, 9, 9, 0, 0, 0, 0, 0);

        // Reset during EXEC: the in-flight op from requester 1 must vanish.
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5; req1_mode = 1'b0;
        #1;
        check("pre_rst_r1", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_r0", 32'(req0_ready), 32'd0);
        check("midrst_r1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        last_g = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("mid-operation reset checked");

        // Both valid continuously: grants must alternate starting with 0.
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), $urandom_range(0, 1),
                      $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), $urandom_range(0, 1), 0);
        end

        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), 1'($urandom),
                $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), $urandom_range(0, 1),
                $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), $urandom_range(0, 1),
                $urandom_range(0, 3));
        end

        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (ripple add/sub datapath width).
REQ-002 SHALL have ports, one per line below; the clock is clk and the reset is rst_n; one clock, synchronous active-low reset.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_mode  input  1  requester 0 op: 0 = A+B, 1 = A-B
- req1_valid, req1_ready, req1_a, req1_b, req1_mode  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester that owns the result
- rsp_out  output  WIDTH  sum/difference
- rsp_cout  output  1  carry out (subtract: 1 = no borrow)

Function
REQ-003 SHALL share one ripple add/sub datapath between two requesters via FSM states IDLE, EXEC, RESP.
REQ-004 IDLE: if any reqN_valid, SHALL assert req<g>_ready for the granted requester g only (combinational, same cycle), capture its a/b/mode/id, go to EXEC; else stay IDLE.
REQ-005 Arbitration SHALL be round-robin: a last-grant pointer holds the last served id; when both valid, grant the other id; when one valid, grant it.
REQ-006 Last-grant pointer SHALL update only on the response handshake (rsp_valid & rsp_ready).
REQ-007 EXEC: SHALL compute out = A + B (mode 0) or A + ~B + 1 (mode 1) on WIDTH bits, cout = carry out of MSB; register into rsp_*; go to RESP.
REQ-008 RESP: rsp_valid SHALL be 1 and rsp_* stable until rsp_ready; on rsp_ready go to IDLE.
REQ-009 Latency: accept at edge N -> rsp_valid high in cycle after edge N+1 (2 cycles); max throughput one op per 3 cycles with rsp_ready held 1.
REQ-010 req0_ready and req1_ready SHALL be 0 outside IDLE and SHALL never be 1 simultaneously.
REQ-011 Operand changes on reqN_* after acceptance SHALL not affect the in-flight result.
REQ-012 Wrap-around: add overflow SHALL wrap modulo 2^WIDTH with cout=1; subtract A<B SHALL wrap with cout=0.
REQ-013 rsp_valid SHALL not depend combinationally on rsp_ready.

Reset
REQ-014 When rst_n=0 at a clock edge: state=IDLE, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_cout=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-015 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight op with no response; reqN_ready SHALL be 0 while rst_n=0.

Configuration
REQ-016 Macro ADDSUB_ARBITER_OVF_EN: when defined, SHALL add output rsp_ovf (1 bit, registered with rsp_*, reset 0) = signed two's-complement overflow of the performed op (operand signs equal after B inversion, result sign differs).
REQ-017 When ADDSUB_ARBITER_OVF_EN is undefined, rsp_ovf SHALL not exist; all other behaviour identical.

Verification
REQ-018 Reset then req0 a=3,b=4,mode=0, rsp_ready=1 -> req0_ready 1 same cycle, 2 cycles later rsp_valid=1, rsp_id=0, rsp_out=7, rsp_cout=0.
REQ-019 req1 a=2,b=5,mode=1 -> rsp_out=13 (1101), rsp_cout=0, rsp_id=1; a=15,b=1,mode=0 -> rsp_out=0, rsp_cout=1.
REQ-020 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; each response id matches grant order.
REQ-021 rsp_ready=0 for 5 cycles in RESP -> rsp_* held stable, no reqN_ready asserted; release -> IDLE next cycle.
REQ-022 rst_n=0 asserted during EXEC -> next cycle rsp_valid=0, no response ever for that op; following req0 granted first.
REQ-023 With ADDSUB_ARBITER_OVF_EN: a=7,b=1,mode=0 -> rsp_out=8, rsp_ovf=1; a=8,b=1,mode=1 -> rsp_out=7, rsp_ovf=1; a=3,b=2,mode=1 -> rsp_ovf=0.
